riscv_mtime_client: RTL and testbench

- Avalon-MM initiator for the memory-mapped RISC-V machine timer.
- Turns single 64-bit requests into the 32-bit word accesses the timer expects:
  - atomic-safe mtime read using the hi-lo-hi sequence;
  - glitch-free mtimecmp update using the lo=all-ones, hi, lo sequence.
- Sits between a management/soft-core command port and the timer's 4-word Avalon slave (word 0 mtime lo, 1 mtime hi, 2 mtimecmp lo, 3 mtimecmp hi).

---
 rtl/riscv_mtime_client.sv | 181 ++++++++++++++++++
 tb/tb_riscv_mtime_client.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mtime_client.sv
// riscv_mtime_client: 64-bit mtime read (hi-lo-hi) and mtimecmp write (lo=max, hi, lo) over a 32-bit Avalon-MM port.
// Latency: read 3(1+L)+1 cycles plus 2(1+L) per retry, write 4; cmd_ready low while busy, responses cannot be stalled.
module riscv_mtime_client #(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [63:0] cmd_data,
    output logic        rsp_valid,
    output logic [63:0] rsp_data,
    output logic        rsp_retry,
    output logic [1:0]  avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD_HI,
        RD_LO,
        RD_HI2,
        WR_LO_MAX,
        WR_HI,
        WR_LO,
        RSP
    } state_t;

    localparam logic [2:0] LAT = 3'(READ_LATENCY);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] hi1_q, hi1_d;
    logic [31:0] lo_q, lo_d;
    logic [63:0] cmd_q, cmd_d;
    logic        retry_q, retry_d;

    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [63:0] rsp_data_q, rsp_data_d;
    logic        rsp_retry_q, rsp_retry_d;
    logic [1:0]  addr_q, addr_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi1_d       = hi1_q;
        lo_d        = lo_q;
        cmd_d       = cmd_q;
        retry_d     = retry_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_retry_d = rsp_retry_q;
        addr_d      = addr_q;
        read_d      = 1'b0;
        write_d     = 1'b0;
        wdata_d     = 32'd0;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    cmd_d   = cmd_data;
                    retry_d = 1'b0;
                    cnt_d   = 3'd0;
                    if (cmd_op) begin
                        state_d = WR_LO_MAX;
                        write_d = 1'b1;
                        addr_d  = 2'd2;
                        wdata_d = 32'hFFFF_FFFF;
                    end else begin
                        state_d = RD_HI;
                        read_d  = 1'b1;
                        addr_d  = 2'd1;
                    end
                end
            end
            // cnt_q counts from the strobe cycle; readdata is valid only when it reaches LAT
            RD_HI, RD_LO, RD_HI2: begin
                if (cnt_q != LAT) begin
                    cnt_d = cnt_q + 3'd1;
                end else begin
                    cnt_d  = 3'd0;
                    read_d = 1'b1;
                    if (state_q == RD_HI) begin
                        hi1_d   = avm_readdata;
                        state_d = RD_LO;
                        addr_d  = 2'd0;
                    end else if (state_q == RD_LO) begin
                        lo_d    = avm_readdata;
                        state_d = RD_HI2;
                        addr_d  = 2'd1;
                    end else if (avm_readdata == hi1_q) begin
                        read_d      = 1'b0;
                        state_d     = RSP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = {hi1_q, lo_q};
                        rsp_retry_d = retry_q;
                    end else begin
                        retry_d = 1'b1;
                        hi1_d   = avm_readdata;
                        state_d = RD_LO;
                        addr_d  = 2'd0;
                    end
                end
            end
            WR_LO_MAX: begin
                state_d = WR_HI;
                write_d = 1'b1;
                addr_d  = 2'd3;
                wdata_d = cmd_q[63:32];
            end
            WR_HI: begin
                state_d = WR_LO;
                write_d = 1'b1;
                addr_d  = 2'd2;
                wdata_d = cmd_q[31:0];
            end
            WR_LO: begin
                state_d     = RSP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = cmd_q;
                rsp_retry_d = 1'b0;
            end
            RSP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            hi1_q       <= 32'd0;
            lo_q        <= 32'd0;
            cmd_q       <= 64'd0;
            retry_q     <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 64'd0;
            rsp_retry_q <= 1'b0;
            addr_q      <= 2'd0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            wdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi1_q       <= hi1_d;
            lo_q        <= lo_d;
            cmd_q       <= cmd_d;
            retry_q     <= retry_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_retry_q <= rsp_retry_d;
            addr_q      <= addr_d;
            read_q      <= read_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_retry     = rsp_retry_q;
    assign avm_address   = addr_q;
    assign avm_read      = read_q;
    assign avm_write     = write_q;
    assign avm_writedata = wdata_q;

endmodule

// File: tb/tb_riscv_mtime_client.sv
// Bench for riscv_mtime_client: two instances (READ_LATENCY 1 and 3) against a timer slave model
// that returns junk outside the sample cycle, checked against an arithmetic model of mtime.
module tb_riscv_mtime_client;

    typedef struct {
        int          rel;
        logic [1:0]  addr;
        logic [31:0] dat;
    } acc_t;

    typedef struct {
        int          rel;
        logic [63:0] dat;
        logic        retry;
    } rsp_t;

    logic clk;
    logic reset_n;
    logic cmd_valid;
    logic cmd_op;
    logic [63:0] cmd_data;
    int   sel;

    logic [1:0]        cmd_vld_g;
    logic [1:0]        cmd_ready, rsp_valid, rsp_retry, avm_read, avm_write;
    logic [1:0][63:0]  rsp_data;
    logic [1:0][1:0]   avm_address;
    logic [1:0][31:0]  avm_writedata;
    logic [1:0][31:0]  avm_readdata;

    assign cmd_vld_g = {cmd_valid && (sel == 1), cmd_valid && (sel == 0)};

    riscv_mtime_client #(.READ_LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_vld_g[0]), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]), .rsp_retry(rsp_retry[0]),
        .avm_address(avm_address[0]), .avm_read(avm_read[0]), .avm_write(avm_write[0]),
        .avm_writedata(avm_writedata[0]), .avm_readdata(avm_readdata[0])
    );

    riscv_mtime_client #(.READ_LATENCY(3)) u_dut_l3 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_vld_g[1]), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]), .rsp_retry(rsp_retry[1]),
        .avm_address(avm_address[1]), .avm_read(avm_read[1]), .avm_write(avm_write[1]),
        .avm_writedata(avm_writedata[1]), .avm_readdata(avm_readdata[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // mtime is a linear counter: base + step per cycle since it was configured
    logic [63:0] mt_base = 64'd0;
    logic [63:0] mt_step = 64'd0;
    int          mt_cyc0 = 0;
    int          cyc     = 0;

    function automatic logic [63:0] mt_at(input int c);
        return mt_base + mt_step * 64'(c - mt_cyc0);
    endfunction

    function automatic logic [31:0] mt_word(input int c, input logic hi);
        logic [63:0] m;
        m = mt_at(c);
        return hi ? m[63:32] : m[31:0];
    endfunction

    function automatic int lat_of(input int i);
        return (i == 1) ? 3 : 1;
    endfunction

    task automatic set_mt(input logic [63:0] base, input logic [63:0] step);
        mt_base = base;
        mt_step = step;
        mt_cyc0 = cyc;
    endtask

    // Reference: reads at t0+1+j(1+L) alternating hi/lo; done when two hi reads around a lo agree
    function automatic void model_read(input int t0_, input int lat, output int r, output logic [63:0] v);
        logic [31:0] hi1, lo, hi2;
        int j;
        hi1 = mt_word(t0_ + 1, 1'b1);
        lo  = 32'd0;
        j   = 1;
        r   = 0;
        for (int n = 0; n < 16; n++) begin
            lo  = mt_word(t0_ + 1 + j * (1 + lat), 1'b0);
            hi2 = mt_word(t0_ + 1 + (j + 1) * (1 + lat), 1'b1);
            if (hi2 == hi1) break;
            r++;
            hi1 = hi2;
            j += 2;
        end
        v = {hi1, lo};
    endfunction

    acc_t        rd_log[$];
    acc_t        wr_log[$];
    rsp_t        rsp_log[$];
    logic [31:0] script[$];
    logic [1:0][63:0] cmp;
    logic [1:0]  pend_v;
    int          pend_due[2];
    logic [31:0] pend_val[2];
    logic [1:0][1:0] last_addr;
    int  t0 = 0;
    bit  busy = 0;
    bit  acc_seen = 0;
    int  irq_cnt = 0, ovl_cnt = 0, wd_viol = 0, ad_viol = 0, rdy_viol = 0;

    initial begin
        pend_v    = '0;
        last_addr = '0;
        cmp       = '0;
    end

    // Slave model and bus monitor, evaluated mid-cycle
    always @(negedge clk) begin
        acc_t e;
        rsp_t r;
        logic [31:0] v;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (pend_v[i] && pend_due[i] == cyc) begin
                avm_readdata[i] = pend_val[i];
                pend_v[i] = 1'b0;
            end else begin
                avm_readdata[i] = $urandom;
            end
            if (!reset_n) pend_v[i] = 1'b0;
            if (reset_n && avm_read[i]) begin
                if (pend_v[i] || avm_write[i]) ovl_cnt++;
                if (i == sel && script.size() > 0) v = script.pop_front();
                else v = mt_word(cyc, avm_address[i][0]);
                pend_v[i]   = 1'b1;
                pend_due[i] = cyc + lat_of(i);
                pend_val[i] = v;
                if (i == sel && busy) begin
                    e.rel = cyc - t0; e.addr = avm_address[i]; e.dat = v;
                    rd_log.push_back(e);
                end
            end
            if (reset_n && avm_write[i]) begin
                if (avm_address[i] == 2'd2) cmp[i][31:0] = avm_writedata[i];
                else if (avm_address[i] == 2'd3) cmp[i][63:32] = avm_writedata[i];
                if (i == sel && busy) begin
                    e.rel = cyc - t0; e.addr = avm_address[i]; e.dat = avm_writedata[i];
                    wr_log.push_back(e);
                end
            end
            if (!avm_write[i] && avm_writedata[i] != 32'd0) wd_viol++;
            if (reset_n && !avm_read[i] && !avm_write[i] && avm_address[i] != last_addr[i]) ad_viol++;
            last_addr[i] = avm_address[i];
        end
        if (!reset_n) begin
            busy = 1'b0;
        end else begin
            if (busy && cmd_ready[sel]) rdy_viol++;
            if (mt_at(cyc) >= cmp[sel]) irq_cnt++;
            if (rsp_valid[sel]) begin
                r.rel = cyc - t0; r.dat = rsp_data[sel]; r.retry = rsp_retry[sel];
                rsp_log.push_back(r);
                busy = 1'b0;
            end
            if (cmd_valid && cmd_ready[sel]) begin
                t0 = cyc;
                busy = 1'b1;
                acc_seen = 1'b1;
            end
        end
    end

    task automatic run_cmd(input bit op, input logic [63:0] d, input bit hold,
                           input bit scripted, input logic [63:0] s_data, input bit s_retry);
        int n, lat, r, nrd, exp_rsp;
        logic [63:0] v;
        rd_log.delete();
        wr_log.delete();
        rsp_log.delete();
        acc_seen = 1'b0;
        irq_cnt  = 0;
        cmd_op    = op;
        cmd_data  = d;
        cmd_valid = 1'b1;
        n = 0;
        while (!acc_seen && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk("accept", 64'(acc_seen), 64'd1);
        if (!acc_seen) begin
            cmd_valid = 1'b0;
            return;
        end
        if (!hold) cmd_valid = 1'b0;
        lat = lat_of(sel);
        if (op) begin
            r = 0; v = d; nrd = 0; exp_rsp = 4;
        end else begin
            if (scripted) begin
                r = s_retry ? 1 : 0; v = s_data;
            end else begin
                model_read(t0, lat, r, v);
            end
            nrd = 3 + 2 * r;
            exp_rsp = nrd * (1 + lat) + 1;
        end
        n = 0;
        while (rsp_log.size() == 0 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("rsp_count", 64'(rsp_log.size()), 64'd1);
        chk("ready_back", 64'(cmd_ready[sel]), 64'd1);
        chk("rsp_pulse", 64'(rsp_valid[sel]), 64'd0);
        if (rsp_log.size() > 0) begin
            chk("rsp_cycle", 64'(rsp_log[0].rel), 64'(exp_rsp));
            chk("rsp_data", rsp_log[0].dat, v);
            chk("rsp_retry", 64'(rsp_log[0].retry), 64'(r != 0));
        end
        chk("rd_count", 64'(rd_log.size()), 64'(nrd));
        for (int k = 0; k < rd_log.size() && k < nrd; k++) begin
            chk("rd_cycle", 64'(rd_log[k].rel), 64'(1 + k * (1 + lat)));
            chk("rd_addr", 64'(rd_log[k].addr), (k % 2 == 0) ? 64'd1 : 64'd0);
        end
        if (op) begin
            chk("wr_count", 64'(wr_log.size()), 64'd3);
            if (wr_log.size() == 3) begin
                chk("wr0", {16'(wr_log[0].rel), 14'd0, wr_log[0].addr, wr_log[0].dat}, {16'd1, 14'd0, 2'd2, 32'hFFFF_FFFF});
                chk("wr1", {16'(wr_log[1].rel), 14'd0, wr_log[1].addr, wr_log[1].dat}, {16'd2, 14'd0, 2'd3, d[63:32]});
                chk("wr2", {16'(wr_log[2].rel), 14'd0, wr_log[2].addr, wr_log[2].dat}, {16'd3, 14'd0, 2'd2, d[31:0]});
            end
            chk("mtimecmp", cmp[sel], d);
        end else begin
            chk("wr_count", 64'(wr_log.size()), 64'd0);
        end
    endtask

    initial begin
        logic [63:0] d, base;
        int n;
        reset_n   = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_data  = 64'd0;
        sel       = 0;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(cmd_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", rsp_data[0] | rsp_data[1], 64'd0);
        chk("rst_rsp_retry", 64'(rsp_retry), 64'd0);
        chk("rst_strobes", {60'd0, avm_read, avm_write}, 64'd0);
        chk("rst_bus", {avm_address, avm_writedata[0] | avm_writedata[1]}, 64'd0);
        reset_n = 1'b1;
        chk("ready_pre_edge", 64'(cmd_ready), 64'd0);
        @(posedge clk); #1;
        chk("ready_first_cycle", 64'(cmd_ready), 64'd3);

        // basic read, L=1
        set_mt(64'h0000_0005_0000_0010, 64'd0);
        run_cmd(1'b0, {$urandom, $urandom}, 1'b0, 1'b0, 64'd0, 1'b0);
        chk("basic_value", rsp_data[0], 64'h0000_0005_0000_0010);

        // rollover between hi reads
        script.push_back(32'd4);
        script.push_back(32'hFFFF_FFFF);
        script.push_back(32'd5);
        script.push_back(32'd2);
        script.push_back(32'd5);
        run_cmd(1'b0, 64'd0, 1'b0, 1'b1, 64'h0000_0005_0000_0002, 1'b1);

        // glitch-free compare update
        set_mt(64'h0000_0001_0000_0000, 64'd0);
        cmp[0] = 64'hFFFF_FFFF_0000_0000;
        run_cmd(1'b1, 64'h0000_0001_2345_6789, 1'b0, 1'b0, 64'd0, 1'b0);
        chk("irq_glitch", 64'(irq_cnt), 64'd0);

        // READ_LATENCY=3
        sel = 1;
        set_mt(64'h0000_00AA_0000_00BB, 64'd0);
        run_cmd(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0);
        chk("l3_value", rsp_data[1], 64'h0000_00AA_0000_00BB);

        // cmd_valid held high, alternating ops
        sel = 0;
        set_mt({$urandom, $urandom}, 64'd0);
        for (int i = 0; i < 6; i++)
            run_cmd(1'(i % 2), {$urandom, $urandom}, 1'b1, 1'b0, 64'd0, 1'b0);
        cmd_valid = 1'b0;

        // reset in the middle of a write
        acc_seen  = 1'b0;
        rsp_log.delete();
        cmd_op    = 1'b1;
        cmd_data  = 64'h0000_0007_0000_0001;
        cmd_valid = 1'b1;
        n = 0;
        while (!acc_seen && n < 40) begin
            @(posedge clk); #1; n++;
        end
        cmd_valid = 1'b0;
        chk("midrst_accept", 64'(acc_seen), 64'd1);
        @(posedge clk); #1;
        chk("midrst_writing", 64'(avm_write[0]), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("midrst_bus", {29'd0, avm_read[0], avm_write[0], avm_address[0], avm_writedata[0]}, 64'd0);
        chk("midrst_ready_rsp", {62'd0, cmd_ready[0], rsp_valid[0]}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_no_rsp", 64'(rsp_log.size()), 64'd0);
        chk("midrst_ready", 64'(cmd_ready[0]), 64'd1);
        set_mt(64'h0000_0123_FFFF_FFF0, 64'd1);
        run_cmd(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0);

        // randomized mix, mtime sometimes near a lo rollover and counting
        for (int it = 0; it < 30; it++) begin
            sel  = int'($urandom_range(0, 1));
            base = {$urandom, ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 20)) : $urandom};
            set_mt(base, 64'($urandom_range(0, 3)));
            d = {$urandom, $urandom};
            run_cmd(1'($urandom_range(0, 1)), d, 1'b0, 1'b0, 64'd0, 1'b0);
        end

        chk("strobe_overlap", 64'(ovl_cnt), 64'd0);
        chk("idle_writedata", 64'(wd_viol), 64'd0);
        chk("idle_addr_hold", 64'(ad_viol), 64'd0);
        chk("ready_while_busy", 64'(rdy_viol), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
